matrix_loader: RTL
==================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter MAX_DIM, default 4: largest accepted square matrix dimension N.
REQ-002 Parameter ADDR_W, default 4: element address width; SHALL satisfy 2**ADDR_W >= MAX_DIM*MAX_DIM.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: inter-byte timeout in clk cycles; used only with LOADER_TIMEOUT_EN.
REQ-004 clk  input  1  clock; same clock as the upstream UART receiver.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 byte_data  input  8  received byte; qualified by byte_valid.
REQ-007 byte_valid  input  1  single-cycle strobe from the UART receiver; one byte per high cycle.
REQ-008 done_ack  input  1  compute-engine acknowledge of load_done.
REQ-009 wr_en  output  1  element write strobe to the matrix buffers.
REQ-010 wr_sel  output  1  0 = matrix A buffer, 1 = matrix B buffer.
REQ-011 wr_addr  output  ADDR_W  row-major element index, row*N + col.
REQ-012 wr_data  output  8  element value.
REQ-013 dim  output  3  latched N; valid while load_done is high.
REQ-014 load_done  output  1  level; both matrices loaded.
REQ-015 err  output  1  single-cycle pulse; frame rejected or aborted.
REQ-016 overrun  output  1  single-cycle pulse; byte dropped in DONE.

Function
REQ-017 FSM states: IDLE, LOAD_A, LOAD_B, DONE; an accepted byte is a byte_valid cycle.
REQ-018 IDLE: accepted byte with 1 <= value <= MAX_DIM latches dim = value and clears idx to 0, then goes to LOAD_A; value 0 or > MAX_DIM pulses err for one cycle and stays in IDLE.
REQ-019 LOAD_A: each accepted byte drives wr_en=1, wr_sel=0, wr_addr=idx, wr_data=byte on the next cycle (latency 1); idx increments.
REQ-020 When idx == N*N-1 in LOAD_A, the accepted byte is written, idx clears to 0 and the FSM goes to LOAD_B.
REQ-021 LOAD_B: same as LOAD_A with wr_sel=1; the last element, idx == N*N-1, goes to DONE.
REQ-022 DONE: load_done=1, dim held; done_ack=1 returns to IDLE next cycle with load_done=0.
REQ-023 byte_valid in DONE without done_ack: byte dropped, overrun pulses one cycle, no write.
REQ-024 byte_valid and done_ack in the same DONE cycle: ack honoured, byte dropped, overrun pulses.
REQ-025 idx width ADDR_W; N*N computed at ADDR_W+1 bits, so no wrap occurs for N = MAX_DIM.
REQ-026 wr_en is never high for more than one cycle per accepted byte; wr_addr/wr_data are don't-care when wr_en=0.
REQ-027 done_ack outside DONE is ignored.

Reset
REQ-028 rst SHALL force IDLE, idx=0, dim=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, load_done=0, err=0, overrun=0, timeout counter=0.
REQ-029 rst asserted mid-load aborts without an err pulse; partially written buffer contents are not cleared.

Configuration
REQ-030 Macro LOADER_TIMEOUT_EN defined: in LOAD_A/LOAD_B, a counter reset by each accepted byte reaching TIMEOUT_CYCLES-1 pulses err and returns to IDLE; a byte arriving on the expiry cycle wins and is accepted.
REQ-031 LOADER_TIMEOUT_EN undefined: no counter is present; LOAD states wait indefinitely.

Structure
REQ-032 A shared package matrix_pkg SHALL hold the FSM state encoding, MAX_DIM default, and WSEL_A/WSEL_B constants.
REQ-033 One sub-module, loader_timeout (counter plus expiry compare), is instantiated only under LOADER_TIMEOUT_EN.

Verification
REQ-034 Bytes 02, 01,02,03,04, 05,06,07,08 -> A[0..3]=1..4, B[0..3]=5..8, each write one cycle after its byte; then load_done=1, dim=2.
REQ-035 Header 00, then header 05 with MAX_DIM=4 -> two err pulses, no wr_en, state IDLE.
REQ-036 Full N=4 load, then byte 0xAA before done_ack -> overrun pulse, no write; done_ack -> load_done=0 next cycle.
REQ-037 rst asserted after 3 of 16 A bytes -> all outputs at reset values; next header 01 loads cleanly.
REQ-038 With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=20: header 02 plus 1 byte, then a 20-cycle gap -> err pulse, IDLE; byte arriving exactly at expiry -> accepted, no err.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix loader: FSM encoding, default size, buffer selects.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MAX_DIM_DEF = 4;

  localparam logic WSEL_A = 1'b0;
  localparam logic WSEL_B = 1'b1;

endpackage

// File: rtl/matrix_loader_timeout.sv
// Inter-byte timeout for the loader: free-running while loading, cleared by each accepted byte.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Saturates at the expiry value; the FSM leaves the load state on that cycle anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (!run || clr) cnt <= '0;
    else if (!expire)     cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/matrix_loader.sv
// Byte-stream loader: header N, then N*N bytes of A and N*N bytes of B into the matrix buffers.
// Optional inter-byte timeout enabled with `define LOADER_TIMEOUT_EN.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int MAX_DIM        = MAX_DIM_DEF,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              done_ack,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [2:0]        dim,
  output logic              load_done,
  output logic              err,
  output logic              overrun
);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   last_idx;
  logic              is_last;
  logic              hdr_ok;
  logic              in_load;
  logic              tmo_expire;

  // One extra bit so N*N-1 never wraps when N == MAX_DIM.
  assign last_idx = (ADDR_W+1)'(dim) * (ADDR_W+1)'(dim) - (ADDR_W+1)'(1);
  assign is_last  = ({1'b0, idx} == last_idx);
  assign hdr_ok   = (byte_data != 8'd0) && (byte_data <= 8'(MAX_DIM));
  assign in_load  = (state == LOAD_A) || (state == LOAD_B);

`ifdef LOADER_TIMEOUT_EN
  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (in_load),
    .clr    (byte_valid),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      dim       <= '0;
      wr_en     <= 1'b0;
      wr_sel    <= WSEL_A;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_valid) begin
            if (hdr_ok) begin
              dim   <= byte_data[2:0];
              idx   <= '0;
              state <= LOAD_A;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          if (byte_valid) begin
            wr_en   <= 1'b1;
            wr_sel  <= (state == LOAD_B) ? WSEL_B : WSEL_A;
            wr_addr <= idx;
            wr_data <= byte_data;
            if (is_last) begin
              idx <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                state     <= DONE;
                load_done <= 1'b1;
              end
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end else if (tmo_expire) begin
            // A byte on the expiry cycle takes the branch above instead.
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: begin
          overrun <= byte_valid;
          if (done_ack) begin
            load_done <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
